// File: rtl/uart_axil_tx.sv
// rtl/uart_axil_tx.sv - AXI4-Lite slave 8N1 UART transmitter with TX FIFO, baud divisor and TX-empty irq
module uart_axil_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] W_IDLE = 1'b0, W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0, R_RESP = 1'b1;
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  logic [0:0]       w_state_q, w_state_d, r_state_q, r_state_d;
  logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             irq_en_q, irq_en_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       s_state_q, s_state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, bdiv_q, bdiv_d, div_eff;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic        aw_fire, ar_fire, push, push_ok, pop, ovf_clr;
  logic        fifo_empty, fifo_full, busy, tx_empty;
  logic [31:0] status, div_wr;
  logic        unused_addr;

  assign unused_addr = ^{araddr[31:4], awaddr[31:4]};

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    busy       = (s_state_q != S_IDLE);
    tx_empty   = fifo_empty && !busy;
    status     = (32'(count_q) << 8) | {28'd0, busy, ovf_q, fifo_full, tx_empty};
  end

  always_comb begin
    aw_fire   = (w_state_q == W_IDLE) && awvalid && wvalid;
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    div_d     = div_q;
    irq_en_d  = irq_en_q;
    push      = 1'b0;
    div_wr    = 32'(div_q);
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) div_wr[8*b +: 8] = wdata[8*b +: 8];
    end
    if (aw_fire) begin
      w_state_d = W_RESP;
      bresp_d   = (awaddr[1:0] != 2'b00) ? 2'b10 : 2'b00;
      if (awaddr[1:0] == 2'b00) begin
        case (awaddr[3:2])
          2'd0:    push = wstrb[0];
          2'd2:    div_d = div_wr[DIV_W-1:0];
          2'd3:    if (wstrb[0]) irq_en_d = wdata[0];
          default: ;
        endcase
      end
    end else if ((w_state_q == W_RESP) && bready) begin
      w_state_d = W_IDLE;
    end
  end

  always_comb begin
    ar_fire   = (r_state_q == R_IDLE) && arvalid;
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ovf_clr   = 1'b0;
    if (ar_fire) begin
      r_state_d = R_RESP;
      rdata_d   = '0;
      rresp_d   = (araddr[1:0] != 2'b00) ? 2'b10 : 2'b00;
      if (araddr[1:0] == 2'b00) begin
        case (araddr[3:2])
          2'd1: begin
            rdata_d = status;
            ovf_clr = 1'b1;
          end
          2'd2:    rdata_d = 32'(div_q);
          2'd3:    rdata_d = {31'd0, irq_en_q};
          default: ;
        endcase
      end
    end else if ((r_state_q == R_RESP) && rready) begin
      r_state_d = R_IDLE;
    end
  end

  // Divisor is latched per byte; end of STOP may chain straight into the next START.
  always_comb begin
    div_eff   = (div_q == '0) ? DIV_W'(1) : div_q;
    s_state_d = s_state_q;
    cnt_d     = cnt_q;
    bdiv_d    = bdiv_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    if ((s_state_q != S_IDLE) && (cnt_q != '0)) begin
      cnt_d = cnt_q - DIV_W'(1);
    end else begin
      case (s_state_q)
        S_START: begin
          s_state_d = S_DATA;
          bit_d     = 3'd0;
          tx_d      = shift_q[0];
          cnt_d     = bdiv_q - DIV_W'(1);
        end
        S_DATA: begin
          cnt_d = bdiv_q - DIV_W'(1);
          if (bit_q == 3'd7) begin
            s_state_d = S_STOP;
            tx_d      = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
        default: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            s_state_d = S_START;
            shift_d   = mem_q[rptr_q];
            bdiv_d    = div_eff;
            cnt_d     = div_eff - DIV_W'(1);
            tx_d      = 1'b0;
          end else begin
            s_state_d = S_IDLE;
            tx_d      = 1'b1;
          end
        end
      endcase
    end
  end

  // A push into a full FIFO still lands if the serializer pops in the same cycle.
  always_comb begin
    push_ok = push && (!fifo_full || pop);
    mem_d   = mem_q;
    if (push_ok) mem_d[wptr_q] = wdata[7:0];
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop);
    ovf_d   = (ovf_q && !ovf_clr) || (push && !push_ok);
    irq_d   = irq_en_q && tx_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      div_q     <= DIV_W'(DIV_RESET);
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      s_state_q <= S_IDLE;
      cnt_q     <= '0;
      bdiv_q    <= DIV_W'(1);
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      div_q     <= div_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      s_state_q <= s_state_d;
      cnt_q     <= cnt_d;
      bdiv_q    <= bdiv_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign awready = (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_IDLE);
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign tx      = tx_q;
  assign irq     = irq_q;
endmodule
